// File: rtl/ram_load_pkg.sv
// Shared types for the RAM load path: quad width, access-size encoding,
// load FSM states and the alignment rule.
package pkg_ram;

  localparam int RAM_QUAD_SIZE = 64;

  typedef enum logic [1:0] {
    RAM_BYTE = 2'd0,
    RAM_WORD = 2'd1,
    RAM_LONG = 2'd2,
    RAM_QUAD = 2'd3
  } ram_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } ram_state_t;

  // A naturally aligned access never straddles a quad boundary.
  function automatic logic is_aligned(input ram_size_t size, input logic [2:0] offset);
    logic ok;
    case (size)
      RAM_BYTE: ok = 1'b1;
      RAM_WORD: ok = (offset[0] == 1'b0);
      RAM_LONG: ok = (offset[1:0] == 2'b00);
      RAM_QUAD: ok = (offset == 3'b000);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ram_load_extend.sv
// Lane extraction for loads: right-shifts the quad by the byte offset, truncates
// to the access size and sign- or zero-extends back to a full quad.
module quad_rshift_extend
  import pkg_ram::*;
(
  input  logic [RAM_QUAD_SIZE-1:0] data_in,
  input  logic [2:0]               offset,
  input  ram_size_t                size,
  input  logic                     signed_ext,
  output logic [RAM_QUAD_SIZE-1:0] data_out
);

  logic [RAM_QUAD_SIZE-1:0] shifted_s;
  logic                     fill_s;

  // Shift the addressed lane down to bit 0, then extend from the access's top bit.
  always_comb begin
    shifted_s = data_in >> {offset, 3'b000};
    fill_s    = 1'b0;
    data_out  = {RAM_QUAD_SIZE{1'b0}};
    case (size)
      RAM_BYTE: begin
        fill_s   = signed_ext & shifted_s[7];
        data_out = {{56{fill_s}}, shifted_s[7:0]};
      end
      RAM_WORD: begin
        fill_s   = signed_ext & shifted_s[15];
        data_out = {{48{fill_s}}, shifted_s[15:0]};
      end
      RAM_LONG: begin
        fill_s   = signed_ext & shifted_s[31];
        data_out = {{32{fill_s}}, shifted_s[31:0]};
      end
      RAM_QUAD: begin
        data_out = shifted_s;
      end
      default: begin
        data_out = {RAM_QUAD_SIZE{1'b0}};
      end
    endcase
  end

endmodule

// File: rtl/ram_load.sv
// Single-outstanding RAM load unit: accepts a sized byte-address request, reads
// one quad, extracts and extends the addressed lane, and returns it with an error flag.
module ram_load
  import pkg_ram::*;
#(
  parameter int ADDR_W      = 16,
  parameter int RAM_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [1:0]               req_size,
  input  logic                     req_signed,
  output logic                     ram_re,
  output logic [ADDR_W-4:0]        ram_addr,
  input  logic [RAM_QUAD_SIZE-1:0] ram_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [RAM_QUAD_SIZE-1:0] rsp_data,
  output logic                     rsp_err
);

  localparam logic [2:0] LAST_WAIT = 3'(RAM_LATENCY - 1);

  ram_state_t               state_r, state_nx_s;
  logic [ADDR_W-1:0]        addr_r;
  ram_size_t                size_r;
  logic                     signed_r;
  logic [2:0]               cnt_r, cnt_nx_s;
  logic                     ram_re_r, ram_re_nx_s;
  logic                     rsp_valid_r, rsp_valid_nx_s;
  logic [RAM_QUAD_SIZE-1:0] rsp_data_r, rsp_data_nx_s;
  logic                     rsp_err_r, rsp_err_nx_s;
  logic                     accept_s;
  logic                     aligned_s;
  ram_size_t                req_size_s;
  logic [RAM_QUAD_SIZE-1:0] ext_s;

  assign req_size_s = ram_size_t'(req_size);
  assign req_ready  = (state_r == IDLE) && !rst;
  assign accept_s   = req_valid && req_ready;
  assign aligned_s  = is_aligned(req_size_s, req_addr[2:0]);

  assign ram_re    = ram_re_r;
  assign ram_addr  = addr_r[ADDR_W-1:3];
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_err   = rsp_err_r;

  quad_rshift_extend u_extend (
    .data_in    (ram_data),
    .offset     (addr_r[2:0]),
    .size       (size_r),
    .signed_ext (signed_r),
    .data_out   (ext_s)
  );

  // Next state and next values of the registered outputs.
  always_comb begin
    state_nx_s     = state_r;
    cnt_nx_s       = cnt_r;
    ram_re_nx_s    = 1'b0;
    rsp_valid_nx_s = rsp_valid_r;
    rsp_data_nx_s  = rsp_data_r;
    rsp_err_nx_s   = rsp_err_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (aligned_s) begin
            state_nx_s  = ISSUE;
            ram_re_nx_s = 1'b1;
          end else begin
            // Misaligned requests never touch the RAM.
            state_nx_s     = RESP;
            rsp_valid_nx_s = 1'b1;
            rsp_err_nx_s   = 1'b1;
            rsp_data_nx_s  = {RAM_QUAD_SIZE{1'b0}};
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      ISSUE: begin
        state_nx_s = WAIT;
        cnt_nx_s   = 3'd0;
      end
      WAIT: begin
        if (cnt_r == LAST_WAIT) begin
          state_nx_s     = RESP;
          rsp_valid_nx_s = 1'b1;
          rsp_err_nx_s   = 1'b0;
          rsp_data_nx_s  = ext_s;
        end else begin
          cnt_nx_s = cnt_r + 3'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nx_s     = IDLE;
          rsp_valid_nx_s = 1'b0;
          rsp_err_nx_s   = 1'b0;
          rsp_data_nx_s  = {RAM_QUAD_SIZE{1'b0}};
        end else begin
          state_nx_s = RESP;
        end
      end
      default: begin
        state_nx_s     = IDLE;
        rsp_valid_nx_s = 1'b0;
        rsp_err_nx_s   = 1'b0;
        rsp_data_nx_s  = {RAM_QUAD_SIZE{1'b0}};
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Output registers and the wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r       <= 3'd0;
      ram_re_r    <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {RAM_QUAD_SIZE{1'b0}};
      rsp_err_r   <= 1'b0;
    end else begin
      cnt_r       <= cnt_nx_s;
      ram_re_r    <= ram_re_nx_s;
      rsp_valid_r <= rsp_valid_nx_s;
      rsp_data_r  <= rsp_data_nx_s;
      rsp_err_r   <= rsp_err_nx_s;
    end
  end

  // Request capture; req_* are ignored outside the accept cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r   <= {ADDR_W{1'b0}};
      size_r   <= RAM_BYTE;
      signed_r <= 1'b0;
    end else if (accept_s) begin
      addr_r   <= req_addr;
      size_r   <= req_size_s;
      signed_r <= req_signed;
    end
  end

endmodule

// File: doc/ram_load.md
RAM_LOAD -- requirements
Module: ram_load

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: byte-address width.
REQ-002 SHALL have parameter RAM_LATENCY, default 1, range 1..4: cycles from ram_re to valid ram_data.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1: load request present.
REQ-006 SHALL have port req_ready, output, 1: request accepted when req_valid && req_ready.
REQ-007 SHALL have port req_addr, input, ADDR_W: byte address.
REQ-008 SHALL have port req_size, input, 2: ram_size_t (RAM_BYTE, RAM_WORD, RAM_LONG, RAM_QUAD).
REQ-009 SHALL have port req_signed, input, 1: 1 = sign-extend, 0 = zero-extend.
REQ-010 SHALL have port ram_re, output, 1: RAM read strobe.
REQ-011 SHALL have port ram_addr, output, ADDR_W-3: quad index.
REQ-012 SHALL have port ram_data, input, RAM_QUAD_SIZE: read quad.
REQ-013 SHALL have port rsp_valid, output, 1: response present.
REQ-014 SHALL have port rsp_ready, input, 1: consumer accepts the response.
REQ-015 SHALL have port rsp_data, output, RAM_QUAD_SIZE: extracted, extended value.
REQ-016 SHALL have port rsp_err, output, 1: misaligned request.

Function
REQ-017 SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP.
REQ-018 SHALL drive req_ready = (state==IDLE) && !rst.
REQ-019 SHALL register addr, size and signed on acceptance; later changes on req_* SHALL have no effect.
REQ-020 Alignment: byte any; word addr[0]=0; long addr[1:0]=0; quad addr[2:0]=0.
REQ-021 Misaligned accept SHALL go IDLE->RESP with rsp_err=1 and rsp_data=0, and SHALL NOT assert ram_re.
REQ-022 Aligned accept SHALL go IDLE->ISSUE; in ISSUE, ram_re=1 for exactly one cycle with ram_addr=addr[ADDR_W-1:3].
REQ-023 WAIT SHALL count RAM_LATENCY cycles, capture ram_data on the last one, then enter RESP.
REQ-024 Byte lane k (k=addr[2:0]) SHALL occupy ram_data bits [8k+7:8k]; the quad SHALL be shifted right by 8k, giving the inverse of the store-side left shift.
REQ-025 The shifted value SHALL be truncated to 8/16/32/64 bits per size, then sign- or zero-extended to 64 bits; RAM_QUAD SHALL ignore req_signed.
REQ-026 In RESP, rsp_valid=1 and rsp_data/rsp_err SHALL be held stable until rsp_ready; on handshake the FSM SHALL return to IDLE.
REQ-027 Latency, accept at cycle 0, aligned: ram_re at cycle 1, rsp_valid at cycle 2+RAM_LATENCY.
REQ-028 Latency, accept at cycle 0, misaligned: rsp_valid at cycle 1.
REQ-029 Throughput SHALL be at most one outstanding request; no new acceptance until the response handshake completes.
REQ-030 rsp_data and rsp_err SHALL be 0 whenever rsp_valid=0.

Reset
REQ-031 rst SHALL asynchronously force state=IDLE and ram_re=0, rsp_valid=0, rsp_data=0, rsp_err=0.
REQ-032 A reset mid-operation, in ISSUE/WAIT/RESP, SHALL discard the request silently; ram_data arriving afterwards SHALL be ignored.
REQ-033 On the first clock after rst deasserts, req_ready SHALL be 1.

Structure
REQ-034 pkg_ram SHALL hold RAM_QUAD_SIZE, the ram_size_t enum (RAM_BYTE, RAM_WORD, RAM_LONG, RAM_QUAD) and the FSM state typedef.
REQ-035 Extraction plus extension SHALL be one combinational sub-module, quad_rshift_extend, with ports data_in, offset[2:0], size, signed and data_out.
REQ-036 The implementation target SHALL be 120-400 RTL lines.

Verification
All scenarios use ram_data = 64'h8877_6655_4433_2211 and RAM_LATENCY=1 unless stated.
REQ-037 Byte, addr 0x0007, signed -> rsp_data=64'hFFFF_FFFF_FFFF_FF88, rsp_err=0, rsp_valid at cycle 3; unsigned -> 64'h88.
REQ-038 Word, addr 0x0006, signed -> 64'hFFFF_FFFF_FFFF_8877; long, addr 0x0004, unsigned -> 64'h0000_0000_8877_6655.
REQ-039 Quad, addr 0x0003 -> rsp_err=1, rsp_data=0, rsp_valid at cycle 1, ram_re never asserted.
REQ-040 rsp_ready held low for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_err stable; req_ready=0; exactly one acceptance.
REQ-041 rst pulsed during WAIT -> all outputs 0 immediately; a following byte request at addr 0x0000 returns 64'h11.
REQ-042 RAM_LATENCY=3, long at addr 0x0000, signed -> rsp_data=64'h0000_0000_4433_2211 at cycle 5.
